// File: rtl/datapath_control_fsm.sv
// Multicycle control unit for an RV32I load-store datapath.
// Steps every instruction through FETCH/DECODE/EXEC/(MEM)/WB and drives the
// datapath selects and write enables from the IR fields.
// Keeps a wrapping retired-instruction counter.
// Parks in HALT on any opcode outside the supported set.
module datapath_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             ula_zero,
  output logic             ULA_din2_sel,
  output logic [1:0]       ULA_op,
  output logic [1:0]       RF_din_sel,
  output logic             WE_RF,
  output logic             WE_MEM,
  output logic             load_pc,
  output logic             reset_pc,
  output logic             pc_next_sel,
  output logic             pc_adder_sel,
  output logic             load_ir,
  output logic             reset_ir,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] retired_r;

  logic       is_load_s, is_store_s, is_op_s, is_opimm_s;
  logic       is_auipc_s, is_jal_s, is_jalr_s, is_branch_s;
  logic       legal_s, rf_write_s, br_taken_s, sel_active_s;
  logic       sel_din2_s, sel_pc_next_s, sel_pc_adder_s;
  logic [1:0] sel_ula_op_s, sel_rf_din_s;

  // funct7_5 only matters to the ALU decoder fed by ULA_op=10, not to sequencing.
  logic unused_funct7_5_s;
  assign unused_funct7_5_s = funct7_5;

  // Opcode classification and the per-opcode select values.
  always_comb begin
    is_load_s      = (opcode == OPC_LOAD);
    is_store_s     = (opcode == OPC_STORE);
    is_op_s        = (opcode == OPC_OP);
    is_opimm_s     = (opcode == OPC_OPIMM);
    is_auipc_s     = (opcode == OPC_AUIPC);
    is_jal_s       = (opcode == OPC_JAL);
    is_jalr_s      = (opcode == OPC_JALR);
    is_branch_s    = (opcode == OPC_BRANCH);
    legal_s        = is_load_s | is_store_s | is_op_s | is_opimm_s |
                     is_auipc_s | is_jal_s | is_jalr_s | is_branch_s;
    rf_write_s     = is_load_s | is_op_s | is_opimm_s | is_auipc_s | is_jal_s | is_jalr_s;
    // Only BEQ and BNE are recognised; any other funct3 falls through untaken.
    br_taken_s     = is_branch_s & (((funct3 == 3'b000) & ula_zero) |
                                    ((funct3 == 3'b001) & ~ula_zero));
    sel_din2_s     = is_load_s | is_store_s | is_opimm_s | is_jalr_s;
    sel_pc_next_s  = is_jalr_s;
    sel_pc_adder_s = is_jal_s | is_auipc_s | br_taken_s;
    if (is_branch_s) begin
      sel_ula_op_s = 2'b01;
    end else if (is_op_s | is_opimm_s) begin
      sel_ula_op_s = 2'b10;
    end else begin
      sel_ula_op_s = 2'b00;
    end
    if (is_op_s | is_opimm_s) begin
      sel_rf_din_s = 2'd1;
    end else if (is_jal_s | is_jalr_s) begin
      sel_rf_din_s = 2'd2;
    end else if (is_auipc_s) begin
      sel_rf_din_s = 2'd3;
    end else begin
      sel_rf_din_s = 2'd0;
    end
  end

  // Sequencer and retired counter; stall freezes everything except INIT.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_INIT;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_INIT:   state_r <= S_FETCH;
        S_FETCH:  state_r <= stall ? S_FETCH : S_DECODE;
        S_DECODE: begin
          if (stall) begin
            state_r <= S_DECODE;
          end else begin
            state_r <= legal_s ? S_EXEC : S_HALT;
          end
        end
        S_EXEC: begin
          if (stall) begin
            state_r <= S_EXEC;
          end else begin
            state_r <= (is_load_s | is_store_s) ? S_MEM : S_WB;
          end
        end
        S_MEM:    state_r <= stall ? S_MEM : S_WB;
        S_WB: begin
          if (stall) begin
            state_r <= S_WB;
          end else begin
            state_r   <= S_FETCH;
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_HALT:   state_r <= S_HALT;
        default:  state_r <= S_INIT;
      endcase
    end
  end

  // Output decode from state and IR fields; stall masks only the enables.
  always_comb begin
    ULA_din2_sel = 1'b0;
    ULA_op       = 2'b00;
    RF_din_sel   = 2'd0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    load_pc      = 1'b0;
    reset_pc     = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    load_ir      = 1'b0;
    reset_ir     = 1'b0;
    halted       = 1'b0;
    sel_active_s = 1'b0;
    case (state_r)
      S_INIT: begin
        reset_pc = 1'b1;
        reset_ir = 1'b1;
      end
      S_FETCH:  load_ir = ~stall;
      S_DECODE: sel_active_s = 1'b0;
      S_EXEC:   sel_active_s = 1'b1;
      S_MEM: begin
        sel_active_s = 1'b1;
        WE_MEM       = is_store_s & ~stall;
      end
      S_WB: begin
        sel_active_s = 1'b1;
        load_pc      = ~stall;
        WE_RF        = rf_write_s & ~stall;
      end
      S_HALT:   halted = 1'b1;
      default:  sel_active_s = 1'b0;
    endcase
    if (sel_active_s) begin
      ULA_din2_sel = sel_din2_s;
      ULA_op       = sel_ula_op_s;
      RF_din_sel   = sel_rf_din_s;
      pc_next_sel  = sel_pc_next_s;
      pc_adder_sel = sel_pc_adder_s;
    end else begin
      ULA_din2_sel = 1'b0;
      ULA_op       = 2'b00;
      RF_din_sel   = 2'd0;
      pc_next_sel  = 1'b0;
      pc_adder_sel = 1'b0;
    end
  end

  assign retired = retired_r;

endmodule

// File: tb/tb_datapath_control_fsm.sv
// Self-checking bench for datapath_control_fsm: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// step-count model of the instruction sequence.
module tb_datapath_control_fsm;

  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] AUI  = 7'b0010111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset_n, stall, funct7_5, ula_zero;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic ULA_din2_sel, WE_RF, WE_MEM, load_pc, reset_pc, pc_next_sel;
  logic pc_adder_sel, load_ir, reset_ir, halted;
  logic [1:0] ULA_op, RF_din_sel;
  logic [31:0] retired;
  logic d4_din2, d4_we_rf, d4_we_mem, d4_load_pc, d4_reset_pc, d4_pc_next;
  logic d4_pc_adder, d4_load_ir, d4_reset_ir, d4_halted;
  logic [1:0] d4_ula_op, d4_rf_din;
  logic [3:0] d4_retired;

  datapath_control_fsm dut (
    .CLK(CLK), .reset_n(reset_n), .stall(stall), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .ula_zero(ula_zero), .ULA_din2_sel(ULA_din2_sel),
    .ULA_op(ULA_op), .RF_din_sel(RF_din_sel), .WE_RF(WE_RF), .WE_MEM(WE_MEM),
    .load_pc(load_pc), .reset_pc(reset_pc), .pc_next_sel(pc_next_sel),
    .pc_adder_sel(pc_adder_sel), .load_ir(load_ir), .reset_ir(reset_ir),
    .halted(halted), .retired(retired)
  );

  datapath_control_fsm #(.CNT_W(4)) dut4 (
    .CLK(CLK), .reset_n(reset_n), .stall(stall), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .ula_zero(ula_zero), .ULA_din2_sel(d4_din2),
    .ULA_op(d4_ula_op), .RF_din_sel(d4_rf_din), .WE_RF(d4_we_rf), .WE_MEM(d4_we_mem),
    .load_pc(d4_load_pc), .reset_pc(d4_reset_pc), .pc_next_sel(d4_pc_next),
    .pc_adder_sel(d4_pc_adder), .load_ir(d4_load_ir), .reset_ir(d4_reset_ir),
    .halted(d4_halted), .retired(d4_retired)
  );

  int checks = 0;
  int errors = 0;

  // Model: m_k is the 1-based cycle number inside the current instruction.
  bit          m_init;
  bit          m_halt;
  int          m_k;
  logic [31:0] m_ret;
  bit          checking = 1'b0;

  logic [6:0] legal_tab [0:7] = '{LD, ST, OPR, OPI, AUI, JAL, JALR, BR};

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {LD, ST, OPR, OPI, AUI, JAL, JALR, BR};
  endfunction
  function automatic int n_of(input logic [6:0] op);
    return (op == LD || op == ST) ? 5 : 4;
  endfunction
  function automatic bit writes(input logic [6:0] op);
    return op inside {LD, OPR, OPI, AUI, JAL, JALR};
  endfunction
  function automatic logic [1:0] exp_rfsel(input logic [6:0] op);
    if (op == OPR || op == OPI) return 2'd1;
    if (op == JAL || op == JALR) return 2'd2;
    if (op == AUI) return 2'd3;
    return 2'd0;
  endfunction
  function automatic logic [1:0] exp_ulaop(input logic [6:0] op);
    if (op == BR) return 2'b01;
    if (op == OPR || op == OPI) return 2'b10;
    return 2'b00;
  endfunction
  function automatic bit exp_pcadd(input logic [6:0] op, input logic [2:0] f3, input logic uz);
    if (op == JAL || op == AUI) return 1'b1;
    if (op == BR) return (f3 == 3'd0 && uz) || (f3 == 3'd1 && !uz);
    return 1'b0;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    m_init  = 1'b1;
    m_halt  = 1'b0;
    m_k     = 0;
    m_ret   = 32'd0;
  endtask

  // One clock: advance the model with the inputs present at the edge.
  task automatic cycle();
    @(posedge CLK);
    if (!reset_n) begin
      m_init = 1'b1;
    end else if (m_init) begin
      m_init = 1'b0;
      m_k    = 1;
    end else if (m_halt || stall) begin
      m_k = m_k;
    end else if (m_k == 2 && !is_legal(opcode)) begin
      m_halt = 1'b1;
      m_k    = 0;
    end else if (m_k == n_of(opcode)) begin
      m_ret = m_ret + 32'd1;
      m_k   = 1;
    end else begin
      m_k = m_k + 1;
    end
    #1;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (checking) begin
      bit act;
      act = !m_init && !m_halt && !stall;
      chk1("reset_pc", reset_pc, m_init);
      chk1("reset_ir", reset_ir, m_init);
      chk1("halted", halted, m_halt);
      chk1("load_ir", load_ir, act && m_k == 1);
      chk1("WE_MEM", WE_MEM, act && m_k == 4 && opcode == ST);
      chk1("WE_RF", WE_RF, act && m_k == n_of(opcode) && writes(opcode));
      chk1("load_pc", load_pc, act && m_k == n_of(opcode));
      chkv("retired", retired, m_ret);
      chkv("retired_w4", 32'(d4_retired), 32'(m_ret[3:0]));
      chk1("halted_w4", d4_halted, m_halt);
      if (!m_init && !m_halt && m_k >= 3) begin
        chk1("ULA_din2_sel", ULA_din2_sel, opcode inside {LD, ST, OPI, JALR});
        chkv("ULA_op", 32'(ULA_op), 32'(exp_ulaop(opcode)));
        chk1("pc_next_sel", pc_next_sel, opcode == JALR);
        chk1("pc_adder_sel", pc_adder_sel, exp_pcadd(opcode, funct3, ula_zero));
        if (m_k == n_of(opcode) && writes(opcode))
          chkv("RF_din_sel", 32'(RF_din_sel), 32'(exp_rfsel(opcode)));
      end
    end
  end

  logic [7:0] we_rf_mask, we_mem_mask, load_pc_mask, load_ir_mask;
  logic       wb_din2, wb_pcnext, wb_pcadd;
  logic [1:0] wb_ulaop, wb_rfsel;
  int         stall_mem_hits;

  // Runs one instruction from FETCH, recording enable cycles and WB selects.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic uz, input int mem_stalls);
    int n;
    n = n_of(op);
    opcode = op; funct3 = f3; funct7_5 = f7; ula_zero = uz; stall = 1'b0;
    we_rf_mask = 8'd0; we_mem_mask = 8'd0; load_pc_mask = 8'd0; load_ir_mask = 8'd0;
    stall_mem_hits = 0;
    for (int c = 1; c <= n; c++) begin
      if (c == 4 && n == 5) begin
        for (int s = 0; s < mem_stalls; s++) begin
          stall = 1'b1;
          @(negedge CLK);
          if (WE_MEM) stall_mem_hits++;
          cycle();
        end
        stall = 1'b0;
      end
      @(negedge CLK);
      we_rf_mask[c] = WE_RF; we_mem_mask[c] = WE_MEM;
      load_pc_mask[c] = load_pc; load_ir_mask[c] = load_ir;
      if (c == n) begin
        wb_din2 = ULA_din2_sel; wb_pcnext = pc_next_sel; wb_pcadd = pc_adder_sel;
        wb_ulaop = ULA_op; wb_rfsel = RF_din_sel;
      end
      cycle();
    end
  endtask

  task automatic pick_instr();
    logic [6:0] op;
    if ($urandom_range(0, 24) == 0) begin
      do op = 7'($urandom_range(0, 127)); while (is_legal(op));
    end else begin
      op = legal_tab[$urandom_range(0, 7)];
    end
    opcode   = op;
    funct3   = $urandom_range(0, 1) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
    funct7_5 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic any_en;
    int   halt_seen;
    int   hcnt;
    stall = 1'b0; opcode = LD; funct3 = 3'd0; funct7_5 = 1'b0; ula_zero = 1'b0;
    assert_reset();
    checking = 1'b1;
    repeat (2) cycle();
    @(negedge CLK);
    chk1("rst reset_pc", reset_pc, 1'b1);
    chk1("rst reset_ir", reset_ir, 1'b1);
    chk1("rst load_ir", load_ir, 1'b0);
    chkv("rst retired", retired, 32'd0);
    cycle();
    reset_n = 1'b1;
    @(negedge CLK);
    chk1("init reset_pc", reset_pc, 1'b1);
    cycle();

    run_instr(LD, 3'd2, 1'b0, 1'b0, 0);
    chkv("ld we_rf cyc", 32'(we_rf_mask), 32'h20);
    chkv("ld load_pc cyc", 32'(load_pc_mask), 32'h20);
    chkv("ld we_mem", 32'(we_mem_mask), 32'h00);
    chkv("ld load_ir cyc", 32'(load_ir_mask), 32'h02);
    chkv("ld rf_din_sel", 32'(wb_rfsel), 32'd0);
    chkv("ld retired", retired, 32'd1);

    run_instr(ST, 3'd2, 1'b0, 1'b0, 0);
    chkv("st we_mem cyc", 32'(we_mem_mask), 32'h10);
    chkv("st we_rf", 32'(we_rf_mask), 32'h00);
    run_instr(OPR, 3'd0, 1'b1, 1'b0, 0);
    chk1("op din2", wb_din2, 1'b0);
    chkv("op ula_op", 32'(wb_ulaop), 32'd2);
    chkv("op rf_din", 32'(wb_rfsel), 32'd1);
    chkv("op we_rf cyc", 32'(we_rf_mask), 32'h10);

    run_instr(BR, 3'd0, 1'b0, 1'b1, 0);
    chk1("beq z=1 pcadd", wb_pcadd, 1'b1);
    chkv("beq z=1 we_rf", 32'(we_rf_mask), 32'h00);
    run_instr(BR, 3'd0, 1'b0, 1'b0, 0);
    chk1("beq z=0 pcadd", wb_pcadd, 1'b0);
    run_instr(BR, 3'd1, 1'b0, 1'b1, 0);
    chk1("bne z=1 pcadd", wb_pcadd, 1'b0);
    run_instr(BR, 3'd1, 1'b0, 1'b0, 0);
    chk1("bne z=0 pcadd", wb_pcadd, 1'b1);
    chkv("bne we_rf", 32'(we_rf_mask), 32'h00);

    run_instr(JAL, 3'd0, 1'b0, 1'b0, 0);
    chkv("jal rf_din", 32'(wb_rfsel), 32'd2);
    chk1("jal pcadd", wb_pcadd, 1'b1);
    chk1("jal pcnext", wb_pcnext, 1'b0);
    run_instr(JALR, 3'd0, 1'b0, 1'b0, 0);
    chk1("jalr pcnext", wb_pcnext, 1'b1);
    chk1("jalr din2", wb_din2, 1'b1);
    run_instr(AUI, 3'd0, 1'b0, 1'b0, 0);
    chkv("auipc rf_din", 32'(wb_rfsel), 32'd3);

    run_instr(ST, 3'd2, 1'b0, 1'b0, 3);
    chkv("st stalled we_mem", 32'(stall_mem_hits), 32'd0);
    chkv("st stalled pulse", 32'(we_mem_mask), 32'h10);
    chkv("dir retired", retired, 32'd11);
    chkv("dir retired_w4", 32'(d4_retired), 32'hB);

    opcode = 7'b0110111;
    repeat (2) begin
      @(negedge CLK);
      cycle();
    end
    any_en = 1'b0; halt_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      any_en = any_en | WE_RF | WE_MEM | load_pc | load_ir;
      if (halted) halt_seen++;
      cycle();
    end
    chkv("halt cycles", 32'(halt_seen), 32'd10);
    chk1("halt enables", any_en, 1'b0);
    assert_reset();
    @(negedge CLK);
    chk1("halt rst reset_pc", reset_pc, 1'b1);
    chk1("halt rst halted", halted, 1'b0);
    cycle();
    reset_n = 1'b1;
    cycle();

    for (int i = 0; i < 15; i++) run_instr(OPI, 3'd0, 1'b0, 1'b0, 0);
    chkv("w4 max", 32'(d4_retired), 32'hF);
    run_instr(OPI, 3'd0, 1'b0, 1'b0, 0);
    chkv("w4 wrap", 32'(d4_retired), 32'h0);
    chkv("w32 after wrap", retired, 32'd16);

    hcnt = 0;
    for (int i = 0; i < 2500; i++) begin
      cycle();
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if (m_halt) begin
        hcnt++;
        if (hcnt >= 10) begin
          hcnt = 0;
          assert_reset();
        end
      end else if ($urandom_range(0, 199) == 0) begin
        assert_reset();
      end
      if (m_k == 1 && !m_init) pick_instr();
      stall    = ($urandom_range(0, 3) == 0);
      ula_zero = 1'($urandom_range(0, 1));
    end

    @(negedge CLK);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
